// File: rtl/lfsr_stream_gen.sv
// Fibonacci LFSR pattern generator with a burst FSM and a valid/ready output stream.
// Each output word is Steps single-bit shifts past the previous state. If the LFSR
// reaches all-zero, it reloads ResetSeed and raises a sticky error flag.
module lfsr_stream_gen #(
  parameter int unsigned          Width     = 32,
  parameter logic [Width-1:0]     Taps      = Width'(32'h80200003),
  parameter int unsigned          Steps     = 32,
  parameter logic [Width-1:0]     ResetSeed = Width'(1),
  parameter int unsigned          CntW      = 32
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             load_i,
  input  logic [Width-1:0] seed_i,
  input  logic             start_i,
  input  logic [CntW-1:0]  length_i,
  input  logic             stop_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CntW-1:0]  word_count_o,
  output logic             lockup_err_o
);

  typedef enum logic [0:0] {StIdle, StRun} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [Width-1:0] state_q, state_d;
  logic [Width-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [CntW-1:0]  remaining_q, remaining_d;
  logic             continuous_q, continuous_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             lockup_q, lockup_d;
  logic             done_q, done_d;

  logic [Width-1:0] lfsr_next;
  logic             accept;
  logic             last_accept;

  // Steps unrolled LFSR shifts from the current state.
  always_comb begin
    lfsr_next = state_q;
    for (int i = 0; i < int'(Steps); i++) begin
      lfsr_next = {lfsr_next[Width-2:0], ^(lfsr_next & Taps)};
    end
  end

  assign accept      = valid_q & out_ready_i;
  assign last_accept = accept & ~continuous_q & (remaining_q == CntW'(1));

  // Burst FSM, handshake, counters and lockup recovery.
  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    data_d       = data_q;
    valid_d      = valid_q;
    remaining_d  = remaining_q;
    continuous_d = continuous_q;
    count_d      = count_q;
    lockup_d     = lockup_q;
    done_d       = 1'b0;

    if (accept) begin
      count_d = count_q + CntW'(1);
    end

    if (load_i) begin
      // Load wins over everything, and a zero seed is taken as-is.
      state_d  = seed_i;
      valid_d  = 1'b0;
      fsm_d    = StIdle;
      count_d  = '0;
      lockup_d = 1'b0;
    end else begin
      case (fsm_q)
        StIdle: begin
          if (start_i) begin
            fsm_d        = StRun;
            remaining_d  = length_i;
            continuous_d = (length_i == '0);
            count_d      = '0;
            lockup_d     = 1'b0;
          end
        end
        StRun: begin
          if (stop_i) begin
            // A pending word is dropped; the LFSR keeps its value.
            fsm_d   = StIdle;
            valid_d = 1'b0;
          end else begin
            if (accept && !continuous_q) begin
              remaining_d = remaining_q - CntW'(1);
            end
            if (last_accept) begin
              valid_d = 1'b0;
              done_d  = 1'b1;
              fsm_d   = StIdle;
            end else if (!valid_q || out_ready_i) begin
              if (state_q == '0) begin
                // The all-zero state is a fixed point, so reseed and skip this slot.
                state_d  = ResetSeed;
                lockup_d = 1'b1;
                valid_d  = 1'b0;
              end else begin
                state_d = lfsr_next;
                data_d  = lfsr_next;
                valid_d = 1'b1;
              end
            end
          end
        end
        default: fsm_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      fsm_q        <= StIdle;
      state_q      <= ResetSeed;
      data_q       <= '0;
      valid_q      <= 1'b0;
      remaining_q  <= '0;
      continuous_q <= 1'b0;
      count_q      <= '0;
      lockup_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      remaining_q  <= remaining_d;
      continuous_q <= continuous_d;
      count_q      <= count_d;
      lockup_q     <= lockup_d;
      done_q       <= done_d;
    end
  end

  assign out_valid_o  = valid_q;
  assign out_data_o   = data_q;
  assign busy_o       = (fsm_q == StRun);
  assign done_o       = done_q;
  assign word_count_o = count_q;
  assign lockup_err_o = lockup_q;

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Bench for lfsr_stream_gen: an 8-bit single-step instance and a default 32-bit instance.
// Expected words come from an arithmetic LFSR reference and a word-level stream monitor.
module tb_lfsr_stream_gen;

  logic clk;
  logic arst;

  // 8-bit instance signals
  logic       load8, start8, stop8, rdy8;
  logic [7:0] seed8, len8, data8, cnt8;
  logic       v8, busy8, done8, lock8;

  // 32-bit instance signals
  logic        load32, start32, stop32, rdy32;
  logic [31:0] seed32, len32, data32, cnt32;
  logic        v32, busy32, done32, lock32;

  int          n_checks;
  int          n_err;
  int          n_acc;
  int          n_done;
  logic [63:0] m_state;
  logic [7:0]  prev_d8;
  bit          hold8;
  logic [7:0]  acc_q[$];
  bit          seen [256];

  lfsr_stream_gen #(
    .Width(8), .Taps(8'hB8), .Steps(1), .ResetSeed(8'h01), .CntW(8)
  ) u_dut8 (
    .clk_i(clk), .arst_i(arst), .load_i(load8), .seed_i(seed8), .start_i(start8),
    .length_i(len8), .stop_i(stop8), .out_valid_o(v8), .out_ready_i(rdy8),
    .out_data_o(data8), .busy_o(busy8), .done_o(done8), .word_count_o(cnt8),
    .lockup_err_o(lock8)
  );

  lfsr_stream_gen u_dut32 (
    .clk_i(clk), .arst_i(arst), .load_i(load32), .seed_i(seed32), .start_i(start32),
    .length_i(len32), .stop_i(stop32), .out_valid_o(v32), .out_ready_i(rdy32),
    .out_data_o(data32), .busy_o(busy32), .done_o(done32), .word_count_o(cnt32),
    .lockup_err_o(lock32)
  );

  always #5 clk = ~clk;

  // Reference LFSR: parity of tapped bits shifted in at the bottom, repeated steps times.
  function automatic logic [63:0] lfsr_ref(input logic [63:0] s, input int w,
                                           input logic [63:0] taps, input int steps);
    logic [63:0] mask;
    logic [63:0] r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    r = s & mask;
    for (int i = 0; i < steps; i++) begin
      r = ((r << 1) | 64'($countones(r & taps) % 2)) & mask;
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: monitor the 8-bit stream at the falling edge, then return just after the rise.
  task automatic cycle();
    logic [63:0] e;
    @(negedge clk);
    if (v8) begin
      if (hold8) begin
        check_eq("hold8", data8, prev_d8);
      end else begin
        e = lfsr_ref((m_state == 0) ? 64'd1 : m_state, 8, 64'hB8, 1);
        check_eq("word8", data8, e);
        m_state = e;
      end
      prev_d8 = data8;
      hold8   = !rdy8;
      if (rdy8) begin
        n_acc++;
        acc_q.push_back(data8);
      end
    end else begin
      hold8 = 0;
    end
    if (done8) n_done++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [7:0] len);
    len8   = len;
    start8 = 1;
    n_acc  = 0;
    n_done = 0;
    acc_q.delete();
    cycle();
    start8 = 0;
  endtask

  task automatic load_seed(input logic [7:0] s);
    seed8 = s;
    load8 = 1;
    cycle();
    load8   = 0;
    m_state = 64'(s);
  endtask

  // Runs until the FSM leaves RUN, then two more cycles so the Done pulse is counted once.
  task automatic run_until_idle(input string tag, input int max);
    int k;
    k = 0;
    while (busy8 && k < max) begin
      cycle();
      k++;
    end
    check_eq(tag, busy8, 0);
    cycle();
    cycle();
  endtask

  task automatic wait_acc(input string tag, input int n, input int max);
    int k;
    k = 0;
    while (n_acc < n && k < max) begin
      cycle();
      k++;
    end
    check_eq(tag, (n_acc >= n), 1);
  endtask

  initial begin
    logic [7:0]  exp1 [5];
    logic [31:0] e32 [4];
    logic [31:0] prev32;
    logic [63:0] s;
    logic [7:0]  rlen;
    int          rep, k, cyc, dn32;
    bit          hold32, ph;

    exp1 = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    n_checks = 0; n_err = 0; n_acc = 0; n_done = 0;
    m_state = 64'd1; hold8 = 0; prev_d8 = '0;
    clk = 0; arst = 1;
    load8 = 0; start8 = 0; stop8 = 0; rdy8 = 0; seed8 = '0; len8 = '0;
    load32 = 0; start32 = 0; stop32 = 0; rdy32 = 0; seed32 = '0; len32 = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", v8, 0);
    check_eq("rst_data", data8, 0);
    check_eq("rst_busy", busy8, 0);
    check_eq("rst_done", done8, 0);
    check_eq("rst_count", cnt8, 0);
    check_eq("rst_lockup", lock8, 0);
    arst = 0;

    // Five-word burst from seed 01 with the sink always ready
    load_seed(8'h01);
    rdy8 = 1;
    start_burst(8'd5);
    check_eq("t1_lat_valid0", v8, 0);
    check_eq("t1_busy", busy8, 1);
    cycle();
    check_eq("t1_lat_valid1", v8, 1);
    run_until_idle("t1_idle_timeout", 50);
    check_eq("t1_len", acc_q.size(), 5);
    for (int i = 0; i < acc_q.size() && i < 5; i++) check_eq("t1_word", acc_q[i], exp1[i]);
    check_eq("t1_done", n_done, 1);
    check_eq("t1_count", cnt8, 5);

    // Continuous run: maximal period, then past the count wrap
    load_seed(8'h01);
    start_burst(8'd0);
    wait_acc("t2_timeout", 300, 400);
    if (acc_q.size() >= 255) begin
      check_eq("t2_period", acc_q[254], 8'h01);
      for (int i = 0; i < 256; i++) seen[i] = 0;
      rep = 0;
      for (int i = 0; i < 255; i++) begin
        if (seen[acc_q[i]]) rep++;
        seen[acc_q[i]] = 1;
      end
      check_eq("t2_repeats", rep, 0);
    end
    rdy8  = 0;
    stop8 = 1;
    cycle();
    stop8 = 0;
    check_eq("t2_count_wrap", cnt8, 8'(300));
    check_eq("t2_valid", v8, 0);
    check_eq("t2_busy", busy8, 0);
    check_eq("t2_no_done", n_done, 0);

    // Zero seed triggers lockup recovery, then three words follow from the reset seed
    load_seed(8'h00);
    check_eq("t4_lock_clear", lock8, 0);
    rdy8 = 1;
    start_burst(8'd3);
    run_until_idle("t4_idle_timeout", 50);
    check_eq("t4_lockup", lock8, 1);
    check_eq("t4_len", acc_q.size(), 3);
    if (acc_q.size() > 0) check_eq("t4_first", acc_q[0], 8'h02);
    check_eq("t4_done", n_done, 1);
    check_eq("t4_count", cnt8, 3);

    // Stop after the second accept
    start_burst(8'd10);
    check_eq("t5_lock_cleared", lock8, 0);
    wait_acc("t5_timeout", 2, 50);
    stop8 = 1;
    rdy8  = 0;
    cycle();
    stop8 = 0;
    check_eq("t5_valid", v8, 0);
    check_eq("t5_busy", busy8, 0);
    check_eq("t5_count", cnt8, 2);
    cycle();
    cycle();
    check_eq("t5_no_done", n_done, 0);

    // Load while a word is pending
    start_burst(8'd0);
    k = 0;
    while (!v8 && k < 10) begin
      cycle();
      k++;
    end
    check_eq("t6_pending", v8, 1);
    load_seed(8'h5A);
    check_eq("t6_load_valid", v8, 0);
    check_eq("t6_load_busy", busy8, 0);
    check_eq("t6_load_count", cnt8, 0);
    rdy8 = 1;
    start_burst(8'd2);
    run_until_idle("t6_idle_timeout", 50);
    if (acc_q.size() > 0) check_eq("t6_from_seed", acc_q[0], lfsr_ref(64'h5A, 8, 64'hB8, 1));

    // Asynchronous reset mid-burst
    start_burst(8'd0);
    wait_acc("t6_arst_timeout", 3, 50);
    #1 arst = 1;
    #1;
    check_eq("arst_valid", v8, 0);
    check_eq("arst_data", data8, 0);
    check_eq("arst_busy", busy8, 0);
    check_eq("arst_done", done8, 0);
    check_eq("arst_count", cnt8, 0);
    check_eq("arst_lockup", lock8, 0);
    #1 arst = 0;
    m_state = 64'd1;
    hold8   = 0;
    start_burst(8'd1);
    run_until_idle("arst_idle_timeout", 50);
    if (acc_q.size() > 0) check_eq("arst_restart", acc_q[0], 8'h02);
    check_eq("arst_done_after", n_done, 1);

    // Randomized bursts with random backpressure and occasional reloads
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 2) == 0) load_seed(8'($urandom));
      rlen = 8'($urandom_range(1, 8));
      start_burst(rlen);
      k = 0;
      while (busy8 && k < 300) begin
        rdy8 = 1'($urandom_range(0, 1));
        cycle();
        k++;
      end
      check_eq("rnd_timeout", busy8, 0);
      cycle();
      cycle();
      check_eq("rnd_count", cnt8, rlen);
      check_eq("rnd_acc", n_acc, rlen);
      check_eq("rnd_done", n_done, 1);
    end

    // Default 32-bit config, 32 steps per word, ready toggling 1010...
    s = 64'd1;
    for (int i = 0; i < 4; i++) begin
      s = lfsr_ref(s, 32, 64'h80200003, 32);
      e32[i] = s[31:0];
    end
    len32 = 32'd4;
    start32 = 1;
    @(posedge clk);
    #1;
    start32 = 0;
    k = 0; cyc = 0; hold32 = 0; ph = 1; prev32 = '0; dn32 = 0;
    while ((k < 4 || busy32) && cyc < 100) begin
      rdy32 = ph;
      ph = !ph;
      @(negedge clk);
      if (v32) begin
        if (hold32) check_eq("t3_hold", data32, prev32);
        else if (k < 4) check_eq("t3_word", data32, e32[k]);
        prev32 = data32;
        hold32 = !rdy32;
        if (rdy32) k++;
      end else begin
        hold32 = 0;
      end
      if (done32) dn32++;
      @(posedge clk);
      #1;
      cyc++;
    end
    @(negedge clk);
    if (done32) dn32++;
    check_eq("t3_accepts", k, 4);
    check_eq("t3_count", cnt32, 4);
    check_eq("t3_busy", busy32, 0);
    check_eq("t3_done", dn32, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
